// File: rtl/display_arbiter_if.sv
// Requester/display bundle for display_arbiter: two level-held requests with
// their digit vectors, and the registered grants, displayed digits and hold status.
interface display_arbiter_if;
  // Handshake: a requester holds reqN high for as long as it wants the display.
  // gntN high means requester N owns the display and x shows its data. A grant
  // is kept for at least the hold time even if reqN drops, and is released only
  // after hold_done.
  logic        req0;
  logic [15:0] data0;
  logic        req1;
  logic [15:0] data1;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] x;
  logic        hold_done;
  logic [1:0]  state_dbg;

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, x, hold_done, state_dbg
  );

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, x, hold_done, state_dbg
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter giving one of two requesters ownership of a 4-digit display
// for a minimum hold time. Optional macro DISPLAY_ARBITER_PREEMPT_EN lets requester 0 preempt SHOW1.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter logic [15:0] BLANK_CODE  = 16'hBBBB
) (
  input logic              clk,
  input logic              clr,
  display_arbiter_if.slave bus
);

  // One-hot-ish encoding so each grant is a state flop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW0 = 2'b01,
    SHOW1 = 2'b10
  } state_e;

  localparam logic [26:0] HOLD_MAX = 27'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [26:0] cnt_q, cnt_d;
  logic        hd_q, hd_d;
  logic        last_q, last_d;
  logic [15:0] x_q, x_d;
  logic        enter0, enter1, to_idle;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hd_q    <= 1'b0;
      last_q  <= 1'b1;
      x_q     <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hd_q    <= hd_d;
      last_q  <= last_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hd_d    = hd_q;
    last_d  = last_q;
    x_d     = x_q;
    enter0  = 1'b0;
    enter1  = 1'b0;
    to_idle = 1'b0;

    case (state_q)
      IDLE: begin
        // last_q==1 means requester 1 was served last, so 0 wins a tie.
        enter0 = bus.req0 && (!bus.req1 || last_q);
        enter1 = bus.req1 && !enter0;
        to_idle = !enter0 && !enter1;
      end
      SHOW0: begin
        enter1  = hd_q && bus.req1;
        to_idle = hd_q && !bus.req0;
      end
      SHOW1: begin
`ifdef DISPLAY_ARBITER_PREEMPT_EN
        enter0  = bus.req0;
`else
        enter0  = hd_q && bus.req0;
`endif
        to_idle = hd_q && !bus.req1;
      end
      default: to_idle = 1'b1;
    endcase

    if (enter0) begin
      state_d = SHOW0;
      last_d  = 1'b0;
      cnt_d   = '0;
      hd_d    = 1'b0;
      x_d     = bus.data0;
    end else if (enter1) begin
      state_d = SHOW1;
      last_d  = 1'b1;
      cnt_d   = '0;
      hd_d    = 1'b0;
      x_d     = bus.data1;
    end else if (to_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
      hd_d    = 1'b0;
      x_d     = BLANK_CODE;
    end else begin
      // Staying in SHOWn: count toward the hold limit and follow live data.
      hd_d = (cnt_q == HOLD_MAX);
      if (cnt_q != HOLD_MAX) cnt_d = cnt_q + 27'd1;
      if (state_q == SHOW0 && bus.req0) x_d = bus.data0;
      if (state_q == SHOW1 && bus.req1) x_d = bus.data1;
    end
  end

  assign bus.gnt0      = state_q[0];
  assign bus.gnt1      = state_q[1];
  assign bus.x         = x_q;
  assign bus.hold_done = hd_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed, table-driven bench for display_arbiter with HOLD_CYCLES=4.
module tb_display_arbiter;

  typedef struct {
    logic        r0;
    logic [15:0] d0;
    logic        r1;
    logic [15:0] d1;
    logic        eg0;
    logic        eg1;
    logic [15:0] ex;
    logic        ehd;
  } vec_t;

  logic clk;
  logic clr;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  display_arbiter_if bus ();

  display_arbiter #(.HOLD_CYCLES(4), .BLANK_CODE(16'hBBBB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r0, input logic [15:0] d0,
                              input logic r1, input logic [15:0] d1,
                              input logic eg0, input logic eg1,
                              input logic [15:0] ex, input logic ehd);
    vec_t v;
    v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ex = ex; v.ehd = ehd;
    return v;
  endfunction

  task automatic drive(input logic r0, input logic [15:0] d0,
                       input logic r1, input logic [15:0] d1);
    bus.req0  = r0;
    bus.data0 = d0;
    bus.req1  = r1;
    bus.data1 = d1;
  endtask

  task automatic check(input string name, input logic eg0, input logic eg1,
                       input logic [15:0] ex, input logic ehd);
    n_vec++;
    if (bus.gnt0 !== eg0 || bus.gnt1 !== eg1 || bus.x !== ex || bus.hold_done !== ehd) begin
      n_err++;
      $display("FAIL %s: got gnt0=%0b gnt1=%0b x=%h hold_done=%0b, expected gnt0=%0b gnt1=%0b x=%h hold_done=%0b",
               name, bus.gnt0, bus.gnt1, bus.x, bus.hold_done, eg0, eg1, ex, ehd);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Table: inputs applied before an edge, outputs expected after it.
    tbl.push_back(mk(1, 16'h1234, 0, 16'h0000, 1, 0, 16'h1234, 0));
    tbl.push_back(mk(0, 16'h0A05, 0, 16'h0000, 1, 0, 16'h1234, 0));
    tbl.push_back(mk(0, 16'h0A05, 0, 16'h0000, 1, 0, 16'h1234, 0));
    tbl.push_back(mk(0, 16'h0A05, 0, 16'h0000, 1, 0, 16'h1234, 0));
    tbl.push_back(mk(0, 16'h0A05, 0, 16'h0000, 1, 0, 16'h1234, 1));
    tbl.push_back(mk(0, 16'h0A05, 0, 16'h0000, 0, 0, 16'hBBBB, 0));
    // Tie after serving 0: requester 1 first, then alternate.
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 16'h1111, 1, 16'h2222, 0, 1, 16'h2222, i == 4));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 16'h1111, 1, 16'h2222, 1, 0, 16'h1111, i == 4));
    tbl.push_back(mk(1, 16'h1111, 1, 16'h2222, 0, 1, 16'h2222, 0));
    // Live update, then req1 drops before the hold ends; other data never shown.
    tbl.push_back(mk(0, 16'h5555, 1, 16'h3333, 0, 1, 16'h3333, 0));
    tbl.push_back(mk(0, 16'h5555, 0, 16'h4444, 0, 1, 16'h3333, 0));
    tbl.push_back(mk(0, 16'h5555, 0, 16'h4444, 0, 1, 16'h3333, 0));
    tbl.push_back(mk(0, 16'h5555, 0, 16'h4444, 0, 1, 16'h3333, 1));
    tbl.push_back(mk(0, 16'h5555, 0, 16'h4444, 0, 0, 16'hBBBB, 0));
    // Single req1 held past the hold time: hold_done saturates, then release.
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C3, 0, 1, 16'h00C3, 0));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C3, 0, 1, 16'h00C3, 0));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C4, 0, 1, 16'h00C4, 0));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C4, 0, 1, 16'h00C4, 0));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C4, 0, 1, 16'h00C4, 1));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C4, 0, 1, 16'h00C4, 1));
    tbl.push_back(mk(0, 16'h5555, 1, 16'h00C4, 0, 1, 16'h00C4, 1));
    tbl.push_back(mk(0, 16'h5555, 0, 16'h00C4, 0, 0, 16'hBBBB, 0));

    // Reset state, asynchronously applied before any clock edge
    clr = 1'b1;
    drive(0, 16'h0000, 0, 16'h0000);
    #1;
    check("reset", 0, 0, 16'hBBBB, 0);
    @(negedge clk);
    clr = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d]", i), tbl[i].eg0, tbl[i].eg1, tbl[i].ex, tbl[i].ehd);
    end

    // Asynchronous clear while requester 1 owns the display
    @(negedge clk);
    drive(0, 16'h0000, 1, 16'h2222);
    @(posedge clk); #1;
    check("clr_pre0", 0, 1, 16'h2222, 0);
    @(posedge clk); #1;
    check("clr_pre1", 0, 1, 16'h2222, 0);
    #2;
    clr = 1'b1;
    #1;
    check("clr_async", 0, 0, 16'hBBBB, 0);
    @(posedge clk); #1;
    check("clr_held", 0, 0, 16'hBBBB, 0);
    @(negedge clk);
    clr = 1'b0;
    drive(1, 16'h1111, 1, 16'h2222);
    // Held tie after reset: owner 0 first, 5 cycles each, no overlap
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("rr[%0d]", k), ((k / 5) % 2) == 0, ((k / 5) % 2) == 1,
            (((k / 5) % 2) == 0) ? 16'h1111 : 16'h2222, (k % 5) == 4);
    end

    // req0 rises two cycles into SHOW1
    @(negedge clk);
    clr = 1'b1;
    drive(0, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    clr = 1'b0;
    drive(0, 16'h1111, 1, 16'h2222);
    @(posedge clk); #1;
    check("pre_e0", 0, 1, 16'h2222, 0);
    @(posedge clk); #1;
    check("pre_e1", 0, 1, 16'h2222, 0);
    @(negedge clk);
    drive(1, 16'h1111, 1, 16'h2222);
`ifdef DISPLAY_ARBITER_PREEMPT_EN
    @(posedge clk); #1; check("pre_e2", 1, 0, 16'h1111, 0);
    @(posedge clk); #1; check("pre_e3", 1, 0, 16'h1111, 0);
    @(posedge clk); #1; check("pre_e4", 1, 0, 16'h1111, 0);
    @(posedge clk); #1; check("pre_e5", 1, 0, 16'h1111, 0);
`else
    @(posedge clk); #1; check("pre_e2", 0, 1, 16'h2222, 0);
    @(posedge clk); #1; check("pre_e3", 0, 1, 16'h2222, 0);
    @(posedge clk); #1; check("pre_e4", 0, 1, 16'h2222, 1);
    @(posedge clk); #1; check("pre_e5", 1, 0, 16'h1111, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 100000000, minimum number of clk cycles a granted requester owns the display (1 s at 100 MHz); legal range 2..2^27-1.
REQ-002 Parameter BLANK_CODE, default 16'hBBBB, value driven on x while no requester is granted (nibble B = all segments off on the display).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 (stopwatch time) requests the display; level-sensitive.
REQ-006 data0  input  16  requester 0 digit vector, 4 nibbles, digit 3 = data0[15:12].
REQ-007 req1  input  1  requester 1 (message/score) requests the display; level-sensitive.
REQ-008 data1  input  16  requester 1 digit vector, same nibble layout.
REQ-009 gnt0  output  1  registered; high while requester 0 owns the display.
REQ-010 gnt1  output  1  registered; high while requester 1 owns the display.
REQ-011 x  output  16  registered digit vector feeding the 4-digit 7-segment driver.
REQ-012 hold_done  output  1  registered; high once the current owner's minimum hold time has elapsed, low in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SHOW0, SHOW1; gnt0 = (state==SHOW0), gnt1 = (state==SHOW1); gnt0 and gnt1 SHALL never be high together.
REQ-014 IDLE: x = BLANK_CODE, hold counter = 0, hold_done = 0.
REQ-015 IDLE with exactly one req high at cycle N SHALL enter that SHOWn with gntn high and x = datan(N) at cycle N+1 (one-cycle latency).
REQ-016 IDLE with req0 and req1 both high SHALL grant the requester not served last (round-robin pointer last_srv); after reset last_srv = 1, so requester 0 wins the first tie.
REQ-017 On every entry to SHOWn, last_srv SHALL be set to n and the hold counter cleared to 0.
REQ-018 In SHOWn, each cycle reqn is high, x SHALL be reloaded with datan (live update); when reqn is low, x SHALL keep its last loaded value.
REQ-019 Hold counter SHALL be 27 bits, increment by 1 per cycle in SHOWn, and saturate at HOLD_CYCLES-1; hold_done SHALL be high in the cycle after the counter reaches HOLD_CYCLES-1 and remain high until state change.
REQ-020 Before hold_done, SHOWn SHALL not be left for any request change (except REQ-027), even if reqn drops.
REQ-021 With hold_done high in SHOWn: if the other requester's req is high, move to the other SHOW state next cycle; else if reqn is low, move to IDLE next cycle; else stay.
REQ-022 Switching SHOW0<->SHOW1 SHALL be direct, no IDLE cycle; x SHALL carry the new owner's data in the same cycle its gnt rises.
REQ-023 data inputs SHALL be sampled only when the matching gnt is (or is becoming) high; data of the non-granted requester SHALL never appear on x.

Reset
REQ-024 While clr is high, state SHALL be IDLE, gnt0 = gnt1 = 0, hold_done = 0, x = BLANK_CODE, hold counter = 0, last_srv = 1, independent of clk.
REQ-025 clr asserted mid-SHOW SHALL abort ownership immediately; after release, arbitration restarts from IDLE per REQ-015/016 at the first clk edge.
REQ-026 All outputs SHALL come directly from flops (no combinational input-to-output path).

Configuration
REQ-027 Macro DISPLAY_ARBITER_PREEMPT_EN: when defined, req0 high while in SHOW1 SHALL move to SHOW0 next cycle regardless of hold_done (requester 0 preempts); when undefined, SHOW1 is left only per REQ-021 and both requesters are strictly round-robin.

Verification
REQ-028 HOLD_CYCLES=4; reset, then req0=1, data0=16'h1234 at cycle 0 -> cycle 1 gnt0=1, x=16'h1234; cycle 0 x=16'hBBBB.
REQ-029 HOLD_CYCLES=4; req0 pulse 1 cycle, data0=16'h0A05 -> gnt0 high exactly 5 cycles, x holds 16'h0A05, then IDLE with x=16'hBBBB.
REQ-030 HOLD_CYCLES=4; req0 and req1 held high together, data0=16'h1111, data1=16'h2222 -> x alternates 1111/2222, each owner 5 cycles, gnt never overlap, first owner 0.
REQ-031 HOLD_CYCLES=4; in SHOW0, data0 changes 16'h0001->16'h0002 -> x follows next cycle; second request tie after SHOW0 ends goes to requester 1.
REQ-032 HOLD_CYCLES=4; clr pulse while gnt1=1 with x=16'h2222 -> x=16'hBBBB and gnt1=0 asynchronously; after release req0=req1=1 grants requester 0.
REQ-033 With DISPLAY_ARBITER_PREEMPT_EN, HOLD_CYCLES=8; req0 rises 2 cycles into SHOW1 -> next cycle gnt0=1, gnt1=0, x=data0; without macro, switch occurs only after hold_done.
